sha3_padder: RTL and testbench



---
 rtl/sha3_padder_if.sv | 28 ++
 rtl/sha3_padder.sv | 119 +++++++++++
 tb/tb_sha3_padder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sha3_padder_if.sv
// Handshake bundle between the word writer, the padder and the Keccak core.
// Carries the 32-bit word stream (valid/ready plus last/nbytes) and the rate-block output (valid/ready).
// master: the side that drives words in and accepts blocks out; slave: the padder itself.
interface sha3_padder_if #(
    parameter int WORD_W = 32,
    parameter int RATE   = 1088
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic [2:0]        in_nbytes;
    logic              blk_valid;
    logic              blk_ready;
    logic [RATE-1:0]   blk_data;
    logic              blk_last;
    logic              busy;

    modport master (
        output in_valid, in_data, in_last, in_nbytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last, busy
    );
endinterface

// File: rtl/sha3_padder.sv
// Packs 32-bit message words into a rate block, applies SHA3 0x06..0x80 padding, hands blocks to Keccak.
// Latency: final word accepted at t -> blk_valid at t+1; an overflow pad block follows its handshake by 2 cycles.
// Backpressure: single buffer, so in_ready is low while a block waits for blk_ready (and during the pad cycle).
// Ports: clk, rst_n (async active-low); bus.slave carries in_* word stream, blk_* block output and busy.
module sha3_padder #(
    parameter int WORD_W = 32,
    parameter int RATE   = 1088
) (
    input  logic          clk,
    input  logic          rst_n,
    sha3_padder_if.slave  bus
);
    localparam int NWORDS = RATE / WORD_W;
    localparam int NBYTES = RATE / 8;
    localparam int WBYTES = WORD_W / 8;
    localparam int CNT_W  = $clog2(NWORDS);
    localparam int POS_W  = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {S_FILL, S_EMIT, S_PADBLK} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [RATE-1:0]   r_buf, w_buf_nxt;
    logic              r_last, w_last_nxt;
    logic              r_pend, w_pend_nxt;

    logic [WORD_W-1:0] w_word;
    logic [2:0]        w_nb;
    logic [POS_W-1:0]  w_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_last  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_buf   <= w_buf_nxt;
            r_last  <= w_last_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_buf_nxt   = r_buf;
        w_last_nxt  = r_last;
        w_pend_nxt  = r_pend;

        // Non-final words always carry a full word of message bytes.
        w_nb   = bus.in_last ? bus.in_nbytes : 3'd4;
        w_word = bus.in_data;
        for (int b = 0; b < WBYTES; b++) begin
            if (3'(b) >= w_nb) w_word[8*b +: 8] = 8'h00;
        end
        // Byte offset just past the message; where the 0x06 domain byte lands.
        w_pos = POS_W'({r_cnt, 2'b00}) + POS_W'(w_nb);

        case (r_state)
            S_FILL: begin
                if (bus.in_valid) begin
                    w_buf_nxt[WORD_W*int'(r_cnt) +: WORD_W] = w_word;
                    if (bus.in_last) begin
                        w_state_nxt = S_EMIT;
                        if (w_pos < POS_W'(NBYTES)) begin
                            // Bytes past the message are still zero, so a plain write is enough;
                            // when the message ends at byte 134 the two pad bits merge into 0x86.
                            w_buf_nxt[8*int'(w_pos) +: 8] = 8'h06;
                            w_buf_nxt[RATE-1]             = 1'b1;
                            w_last_nxt                    = 1'b1;
                        end else begin
                            // Message exactly fills the block: padding needs a block of its own.
                            w_last_nxt = 1'b0;
                            w_pend_nxt = 1'b1;
                        end
                    end else if (r_cnt == CNT_W'(NWORDS - 1)) begin
                        w_state_nxt = S_EMIT;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_EMIT: begin
                if (bus.blk_ready) begin
                    w_buf_nxt  = '0;
                    w_cnt_nxt  = '0;
                    w_last_nxt = 1'b0;
                    if (r_pend) begin
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = S_PADBLK;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_PADBLK: begin
                // Buffer was cleared on the previous handshake.
                w_buf_nxt[7:0]     = 8'h06;
                w_buf_nxt[RATE-1]  = 1'b1;
                w_last_nxt         = 1'b1;
                w_state_nxt        = S_EMIT;
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == S_FILL);
    assign bus.blk_valid = (r_state == S_EMIT);
    assign bus.blk_data  = r_buf;
    assign bus.blk_last  = r_last;
    assign bus.busy      = (r_state != S_FILL) || (r_cnt != '0);
endmodule

// File: tb/tb_sha3_padder.sv
// Bench for sha3_padder: messages are padded by a byte-level reference model into expected blocks,
// queued when driven, and compared word by word when each block handshakes.
// Also covers reset values, first-block latency, pad-block gap, backpressure hold and mid-fill reset.
module tb_sha3_padder;
    localparam int RATE   = 1088;
    localparam int NBYTES = RATE / 8;
    localparam int NWORDS = RATE / 32;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_hs = 0;
    int   hs_gap  = 0;

    logic [RATE:0] exp_q[$];

    sha3_padder_if #(.WORD_W(32), .RATE(RATE)) bus ();

    sha3_padder #(.WORD_W(32), .RATE(RATE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_last)
            assert (bus.in_nbytes <= 3'd4)
            else $error("FAIL nbytes_range obs=%0d exp<=4", bus.in_nbytes);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every block at the negedge before the edge that completes its handshake.
    always @(negedge clk) begin
        logic [RATE:0] e;
        if (rst_n && bus.blk_valid && bus.blk_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_blk", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                for (int k = 0; k < NWORDS; k++)
                    chk($sformatf("blk_w%0d", k), 64'(bus.blk_data[32*k +: 32]), 64'(e[32*k +: 32]));
                chk("blk_last", 64'(bus.blk_last), 64'(e[RATE]));
                hs_gap  = cyc - last_hs;
                last_hs = cyc;
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
        int  n    = 0;
        bit  done = 0;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.in_nbytes = nb;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
            @(posedge clk); #1;
            n++;
            if (!done && n > 500) begin
                chk("drv_timeout", 64'd1, 64'd0);
                done = 1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // pat: 0 = all 0xA5, 1 = random, 2 = 'a','b','c',...
    task automatic send_msg(input int len, input int pat);
        logic [7:0]    msg[$];
        logic [7:0]    pb[$];
        logic [RATE:0] e;
        logic [31:0]   d;
        int            L, nblk, nw, nb, idx;
        for (int i = 0; i < len; i++)
            msg.push_back(pat == 0 ? 8'hA5 : (pat == 1 ? 8'($urandom) : 8'(8'h61 + i)));
        // Reference pad10*1 with the SHA3 domain suffix.
        L = (len / NBYTES + 1) * NBYTES;
        for (int i = 0; i < L; i++) pb.push_back(i < len ? msg[i] : 8'h00);
        pb[len] = pb[len] ^ 8'h06;
        pb[L-1] = pb[L-1] | 8'h80;
        nblk = L / NBYTES;
        for (int bi = 0; bi < nblk; bi++) begin
            e = '0;
            for (int j = 0; j < NBYTES; j++) e[8*j +: 8] = pb[bi*NBYTES + j];
            e[RATE] = (bi == nblk - 1);
            exp_q.push_back(e);
        end
        nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++) begin
                idx = 4*w + b;
                d[8*b +: 8] = (idx < len) ? msg[idx] : 8'hEE;
            end
            nb = (w == nw - 1) ? len - 4*w : 4;
            send_word(d, w == nw - 1, 3'(nb));
        end
        @(negedge clk);
        chk("lat_blk_valid", 64'(bus.blk_valid), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_nbytes = '0;
        bus.blk_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_blk_valid", 64'(bus.blk_valid), 64'd0);
        chk("rst_blk_last",  64'(bus.blk_last),  64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_blk_data",  64'(|bus.blk_data), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        send_msg(0, 0);   drain();   // empty message
        send_msg(3, 2);   drain();   // "abc"
        send_msg(135, 0); drain();   // 0x86 merge
        send_msg(136, 0); drain();   // extra pad block
        chk("pad_gap", 64'(hs_gap), 64'd2);
        send_msg(1, 1);   drain();
        send_msg(200, 1); drain();
        send_msg(272, 1); drain();

        // Backpressure: block must hold and a waiting word must not be taken.
        bus.blk_ready = 1'b0;
        send_msg(3, 2);
        fork
            send_msg(4, 1);
        join_none
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
            chk("bp_blk_valid", 64'(bus.blk_valid), 64'd1);
            chk("bp_blk_last",  64'(bus.blk_last),  64'd1);
            chk("bp_data_lo",   bus.blk_data[63:0], 64'h0000_0000_0663_6261);
            chk("bp_data_hi",   bus.blk_data[RATE-1 -: 64], 64'h8000_0000_0000_0000);
        end
        @(posedge clk); #1 bus.blk_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_rel_in_ready", 64'(bus.in_ready), 64'd1);
        wait fork;
        drain();

        // Reset in the middle of a fill discards the partial block.
        for (int w = 0; w < 5; w++) send_word(32'hDEAD_0000 | 32'(w), 1'b0, 3'd4);
        @(negedge clk);
        chk("mid_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("mid_rst_blk_valid", 64'(bus.blk_valid), 64'd0);
        chk("mid_rst_busy",      64'(bus.busy),      64'd0);
        chk("mid_rst_blk_data",  64'(|bus.blk_data), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_msg(3, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
